// File: rtl/ex_mem_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg_pkg
// Purpose  : Shared types for the EX/MEM pipeline register: word/register/
//            opcode types, writeback-source encoding, memory-handshake FSM
//            state codes and the packed bundle of latched EX/MEM fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ex_mem_reg_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_LUI   = 6'h0F;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;
  localparam opcode_t OP_HALT  = 6'h3F;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_LUI = 2'd2,
    RS_NPC = 2'd3
  } em_regsrc_t;

  // Memory-handshake FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Everything latched by the register, so a bubble is a single assignment.
  typedef struct packed {
    logic       wen;
    regbits_t   wsel;
    word_t      aluout;
    word_t      rdat2;
    word_t      luiout;
    opcode_t    opcode;
    word_t      npc;
    logic       memren;
    logic       memwen;
    em_regsrc_t regsrc;
    logic       halt;
  } ex_mem_t;

  // All-zero bundle except the PC, which restarts at the reset vector.
  function automatic ex_mem_t em_bubble(input word_t reset_pc);
    ex_mem_t b;
    b     = '0;
    b.npc = reset_pc;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg
// Purpose  : EX/MEM pipeline register. Latches execute-stage results, feeds
//            the forwarding unit and MEM/WB, and owns the data-memory request
//            handshake (IDLE/WAIT/DONE) including the upstream stall.
// Ports    : CLK, nRST          - clock, asynchronous active-low reset
//            en, flush          - pipeline advance / bubble insertion
//            ex_*               - execute-stage results to capture
//            dhit               - data memory completed this cycle
//            em_*               - latched fields to forwarding / MEM/WB
//            dmemREN/WEN/store  - data memory request (address = em_aluout)
//            mem_stall          - freeze upstream while a request is open
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        flush,
  input  logic        ex_wen,
  input  logic [4:0]  ex_wsel,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_rdat2,
  input  logic [31:0] ex_luiout,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_npc,
  input  logic        ex_memren,
  input  logic        ex_memwen,
  input  logic [1:0]  ex_regsrc,
  input  logic        ex_halt,
  input  logic        dhit,
  output logic        em_wen,
  output logic [4:0]  em_wsel,
  output logic [31:0] em_aluout,
  output logic [31:0] em_luiout,
  output logic [5:0]  em_opcode,
  output logic [31:0] em_npc,
  output logic [1:0]  em_regsrc,
  output logic        em_halt,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemstore,
  output logic        mem_stall
);

  ex_mem_t    r_em;
  logic [1:0] r_state;

  ex_mem_t    w_cap;
  ex_mem_t    w_em_next;
  logic [1:0] w_state_next;
  logic       w_load;
  logic       w_wait;

  assign w_wait = (r_state == ST_WAIT);

  // Combinational on dhit so the pipeline advances in the completion cycle.
  assign mem_stall = w_wait & ~dhit;
  assign w_load    = en & ~mem_stall;

  always_comb begin
    // Once halted, only bubbles enter; the halt flag itself is sticky.
    w_cap = em_bubble(RESET_PC);
    if (r_em.halt) begin
      w_cap.halt = 1'b1;
    end else begin
      w_cap.wen    = ex_wen;
      w_cap.wsel   = ex_wsel;
      w_cap.aluout = ex_aluout;
      w_cap.rdat2  = ex_rdat2;
      w_cap.luiout = ex_luiout;
      w_cap.opcode = ex_opcode;
      w_cap.npc    = ex_npc;
      w_cap.memren = ex_memren;
      w_cap.memwen = ex_memwen;
      w_cap.regsrc = em_regsrc_t'(ex_regsrc);
      w_cap.halt   = ex_halt;
    end

    w_em_next    = r_em;
    w_state_next = r_state;
    if (flush) begin
      // Bubble beats en and a pending dhit; halt survives until reset.
      w_em_next      = em_bubble(RESET_PC);
      w_em_next.halt = r_em.halt;
      w_state_next   = ST_IDLE;
    end else if (w_load) begin
      // Any load retires the current op (in WAIT only possible with dhit),
      // so the next state depends solely on the newly captured instruction.
      // This covers IDLE->WAIT, DONE->WAIT and WAIT->WAIT without a gap.
      w_em_next    = w_cap;
      w_state_next = (w_cap.memren | w_cap.memwen) ? ST_WAIT : ST_IDLE;
    end else if (w_wait && dhit) begin
      // Done but downstream frozen: park in DONE so no repeat request.
      w_state_next = ST_DONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_em    <= em_bubble(RESET_PC);
      r_state <= ST_IDLE;
    end else begin
      r_em    <= w_em_next;
      r_state <= w_state_next;
    end
  end

  // $0 is never reported as written.
  assign em_wen    = r_em.wen & (r_em.wsel != 5'd0);
  assign em_wsel   = r_em.wsel;
  assign em_aluout = r_em.aluout;
  assign em_luiout = r_em.luiout;
  assign em_opcode = r_em.opcode;
  assign em_npc    = r_em.npc;
  assign em_regsrc = r_em.regsrc;
  assign em_halt   = r_em.halt;
  assign dmemstore = r_em.rdat2;
  assign dmemREN   = w_wait & r_em.memren;
  assign dmemWEN   = w_wait & r_em.memwen;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_reg
// Purpose  : Self-checking bench for ex_mem_reg: directed scenarios plus a
//            randomized run against a request-outstanding reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  localparam logic [31:0] c_RST_PC = 32'hBFC0_0000;

  logic        CLK = 1'b0;
  logic        nRST, en, flush, ex_wen, ex_memren, ex_memwen, ex_halt, dhit;
  logic [4:0]  ex_wsel;
  logic [31:0] ex_aluout, ex_rdat2, ex_luiout, ex_npc;
  logic [5:0]  ex_opcode;
  logic [1:0]  ex_regsrc;
  logic        em_wen, em_halt, dmemREN, dmemWEN, mem_stall;
  logic [4:0]  em_wsel;
  logic [31:0] em_aluout, em_luiout, em_npc, dmemstore;
  logic [5:0]  em_opcode;
  logic [1:0]  em_regsrc;

  int checks = 0;
  int errors = 0;

  // Reference model: latched fields plus "request outstanding" flag.
  logic        m_wen, m_ren, m_wrn, m_halt, m_pend;
  logic [4:0]  m_wsel;
  logic [31:0] m_alu, m_st, m_lui, m_npc;
  logic [5:0]  m_op;
  logic [1:0]  m_rs;

  ex_mem_reg #(.RESET_PC(c_RST_PC)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .ex_wen(ex_wen), .ex_wsel(ex_wsel), .ex_aluout(ex_aluout),
    .ex_rdat2(ex_rdat2), .ex_luiout(ex_luiout), .ex_opcode(ex_opcode),
    .ex_npc(ex_npc), .ex_memren(ex_memren), .ex_memwen(ex_memwen),
    .ex_regsrc(ex_regsrc), .ex_halt(ex_halt), .dhit(dhit),
    .em_wen(em_wen), .em_wsel(em_wsel), .em_aluout(em_aluout),
    .em_luiout(em_luiout), .em_opcode(em_opcode), .em_npc(em_npc),
    .em_regsrc(em_regsrc), .em_halt(em_halt), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemstore(dmemstore), .mem_stall(mem_stall)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic model_bubble();
    m_wen = 0; m_wsel = 0; m_alu = 0; m_st = 0; m_lui = 0; m_op = 0;
    m_npc = c_RST_PC; m_rs = 0; m_ren = 0; m_wrn = 0; m_pend = 0;
  endtask

  task automatic drive_ex(input logic wen, input logic [4:0] wsel, input logic [31:0] alu,
                          input logic [31:0] st, input logic [5:0] op, input logic ren,
                          input logic wrn, input logic [1:0] rs, input logic halt);
    ex_wen = wen; ex_wsel = wsel; ex_aluout = alu; ex_rdat2 = st;
    ex_luiout = {alu[15:0], 16'h0}; ex_opcode = op; ex_npc = alu + 32'd4;
    ex_memren = ren; ex_memwen = wrn; ex_regsrc = rs; ex_halt = halt;
  endtask

  // One clock: advance the model by the rules, then settle 1 time unit.
  task automatic tick();
    logic st, ld;
    st = m_pend & ~dhit;
    ld = en & ~st;
    @(posedge CLK);
    if (flush) begin
      model_bubble();
    end else if (ld) begin
      if (m_halt) begin
        model_bubble();
      end else begin
        m_wen = ex_wen; m_wsel = ex_wsel; m_alu = ex_aluout; m_st = ex_rdat2;
        m_lui = ex_luiout; m_op = ex_opcode; m_npc = ex_npc; m_rs = ex_regsrc;
        m_ren = ex_memren; m_wrn = ex_memwen; m_halt = ex_halt;
      end
      m_pend = m_ren | m_wrn;
    end else if (dhit) begin
      m_pend = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (em_npc !== c_RST_PC) begin errors++; $display("FAIL reset_npc got %h exp %h", em_npc, c_RST_PC); end
    checks++; if ({em_wen, em_wsel, em_aluout, em_luiout, em_opcode, em_regsrc, em_halt} !== '0) begin
      errors++; $display("FAIL reset_fields got nonzero alu=%h wsel=%0d", em_aluout, em_wsel); end
    checks++; if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
      errors++; $display("FAIL reset_handshake got %b exp 000", {dmemREN, dmemWEN, mem_stall}); end
    #1 nRST = 1;
  endtask

  task automatic test_alu();
    en = 1; drive_ex(1, 5'd5, 32'h1234, 32'h0, OP_RTYPE, 0, 0, RS_ALU, 0);
    tick();
    checks++; if (em_wen !== 1'b1 || em_wsel !== 5'd5) begin errors++; $display("FAIL alu_wsel got %b/%0d exp 1/5", em_wen, em_wsel); end
    checks++; if (em_aluout !== 32'h1234) begin errors++; $display("FAIL alu_out got %h exp 1234", em_aluout); end
    checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL alu_nomem got %b%b exp 00", dmemREN, mem_stall); end
  endtask

  task automatic test_load_latency();
    en = 1; dhit = 0;
    drive_ex(1, 5'd3, 32'h0000_0400, 32'h0, OP_LW, 1, 0, RS_MEM, 0);
    tick();
    drive_ex(1, 5'd7, 32'hDEAD_0000, 32'h0, OP_RTYPE, 0, 0, RS_ALU, 0);
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 2); en = (i != 2);
      #1;
      checks++; if (dmemREN !== 1'b1) begin errors++; $display("FAIL lw_ren cyc %0d got %b exp 1", i, dmemREN); end
      checks++; if (mem_stall !== (i != 2)) begin errors++; $display("FAIL lw_stall cyc %0d got %b exp %b", i, mem_stall, i != 2); end
      checks++; if (em_aluout !== 32'h0000_0400) begin errors++; $display("FAIL lw_hold cyc %0d got %h exp 400", i, em_aluout); end
      tick();
    end
    en = 0;
    for (int j = 0; j < 2; j++) begin
      dhit = (j == 0);
      #1;
      checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
        errors++; $display("FAIL lw_oneshot cyc %0d got ren=%b stall=%b exp 0 0", j, dmemREN, mem_stall); end
      checks++; if (em_aluout !== 32'h0000_0400) begin errors++; $display("FAIL lw_done_hold got %h exp 400", em_aluout); end
      tick();
    end
    dhit = 0; en = 1;
    tick();
    checks++; if (em_aluout !== 32'hDEAD_0000 || dmemREN !== 1'b0) begin
      errors++; $display("FAIL lw_next got %h ren=%b exp dead0000 0", em_aluout, dmemREN); end
  endtask

  task automatic test_back_to_back();
    en = 1; dhit = 0;
    drive_ex(0, 5'd0, 32'h0000_0100, 32'hCAFE_F00D, OP_SW, 0, 1, RS_ALU, 0);
    tick();
    checks++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_sw got wen=%b ren=%b st=%h exp 1 0 cafef00d", dmemWEN, dmemREN, dmemstore); end
    drive_ex(1, 5'd9, 32'h0000_0200, 32'h0, OP_LW, 1, 0, RS_MEM, 0);
    dhit = 1;
    tick();
    checks++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || em_aluout !== 32'h200) begin
      errors++; $display("FAIL b2b_lw got ren=%b wen=%b addr=%h exp 1 0 200", dmemREN, dmemWEN, em_aluout); end
    // Completion while frozen, then a store enters straight from the parked state.
    en = 0;
    tick();
    dhit = 0;
    #1;
    checks++; if (dmemREN !== 1'b0) begin errors++; $display("FAIL b2b_parked got ren=%b exp 0", dmemREN); end
    en = 1;
    drive_ex(0, 5'd0, 32'h0000_0300, 32'h1111_2222, OP_SW, 0, 1, RS_ALU, 0);
    tick();
    checks++; if (dmemWEN !== 1'b1 || em_aluout !== 32'h300) begin
      errors++; $display("FAIL b2b_done_wait got wen=%b addr=%h exp 1 300", dmemWEN, em_aluout); end
    dhit = 1;
    drive_ex(0, 5'd0, 32'h0, 32'h0, OP_RTYPE, 0, 0, RS_ALU, 0);
    tick();
    dhit = 0;
  endtask

  task automatic test_flush_wait();
    en = 1; dhit = 0;
    drive_ex(1, 5'd4, 32'h0000_0800, 32'h0, OP_LW, 1, 0, RS_MEM, 0);
    tick();
    flush = 1; dhit = 1;
    tick();
    flush = 0; dhit = 0;
    checks++; if ({em_wen, em_wsel, em_aluout, em_opcode} !== '0 || em_npc !== c_RST_PC) begin
      errors++; $display("FAIL flush_fields got alu=%h npc=%h exp 0 %h", em_aluout, em_npc, c_RST_PC); end
    checks++; if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL flush_req got ren=%b stall=%b exp 0 0", dmemREN, mem_stall); end
  endtask

  task automatic test_zero_reg();
    en = 1;
    drive_ex(1, 5'd0, 32'h5555_AAAA, 32'h0, OP_RTYPE, 0, 0, RS_ALU, 0);
    tick();
    checks++; if (em_wen !== 1'b0 || em_aluout !== 32'h5555_AAAA) begin
      errors++; $display("FAIL zero_reg got wen=%b alu=%h exp 0 5555aaaa", em_wen, em_aluout); end
  endtask

  task automatic test_async_reset();
    en = 1; dhit = 0;
    drive_ex(0, 5'd0, 32'h0000_0900, 32'h0BAD_BEEF, OP_SW, 0, 1, RS_ALU, 0);
    tick();
    checks++; if (dmemWEN !== 1'b1 || mem_stall !== 1'b1) begin
      errors++; $display("FAIL areset_pre got wen=%b stall=%b exp 1 1", dmemWEN, mem_stall); end
    #2 nRST = 0;
    #1;
    checks++; if (dmemWEN !== 1'b0 || mem_stall !== 1'b0 || em_npc !== c_RST_PC || em_aluout !== 32'h0) begin
      errors++; $display("FAIL areset got wen=%b stall=%b npc=%h alu=%h", dmemWEN, mem_stall, em_npc, em_aluout); end
    model_bubble(); m_halt = 0;
    #2 nRST = 1;
  endtask

  task automatic test_random();
    logic [145:0] exp_v, act_v;
    int r;
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      dhit  = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 3);
      ex_wen = 1'($urandom); ex_wsel = 5'($urandom); ex_aluout = $urandom; ex_rdat2 = $urandom;
      ex_luiout = $urandom; ex_opcode = 6'($urandom); ex_npc = $urandom; ex_regsrc = 2'($urandom);
      ex_memren = (r == 1); ex_memwen = (r == 2); ex_halt = 0;
      tick();
      exp_v = {m_wen & (m_wsel != 0), m_wsel, m_alu, m_lui, m_op, m_npc, m_rs, m_halt,
               m_pend & m_ren, m_pend & m_wrn, m_st, m_pend & ~dhit};
      act_v = {em_wen, em_wsel, em_aluout, em_luiout, em_opcode, em_npc, em_regsrc, em_halt,
               dmemREN, dmemWEN, dmemstore, mem_stall};
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, act_v, exp_v);
      end
    end
    flush = 0; dhit = 0;
  endtask

  task automatic test_halt();
    en = 1; dhit = 0;
    drive_ex(0, 5'd0, 32'h0, 32'h0, OP_HALT, 0, 0, RS_ALU, 1);
    tick();
    checks++; if (em_halt !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", em_halt); end
    for (int i = 0; i < 10; i++) begin
      drive_ex(1, 5'($urandom_range(1, 31)), $urandom, $urandom, OP_LW, 1, 0, RS_MEM, 0);
      tick();
      checks++; if (em_halt !== 1'b1 || dmemREN !== 1'b0 || em_wen !== 1'b0 || em_aluout !== 32'h0) begin
        errors++; $display("FAIL halt_hold load %0d got halt=%b ren=%b wen=%b alu=%h", i, em_halt, dmemREN, em_wen, em_aluout); end
    end
  endtask

  initial begin
    nRST = 0; en = 0; flush = 0; dhit = 0;
    drive_ex(0, 5'd0, 32'h0, 32'h0, OP_RTYPE, 0, 0, RS_ALU, 0);
    model_bubble(); m_halt = 0;
    test_reset();
    test_alu();
    test_load_latency();
    test_back_to_back();
    test_flush_wait();
    test_zero_reg();
    test_async_reset();
    test_random();
    test_async_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
